lavadora_param: RTL

LAVADORA_PARAM -- requirements
Module: lavadora_param

---
 rtl/lavadora_param.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/lavadora_param.sv
// Coin-operated laundry controller: collects credit, starts one of three timed
// services, and returns change or refunds one coin per cycle.
module lavadora_param #(
    parameter int CNT_W         = 5,
    parameter int PRECIO_SECADO = 3,
    parameter int PRECIO_LAVADO = 4,
    parameter int PRECIO_PESADO = 9,
    parameter int T_SECADO      = 8,
    parameter int T_LAVADO      = 12,
    parameter int T_PESADO      = 20,
    parameter int TIMEOUT       = 50
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             intro_moneda,
    input  logic [1:0]       sel_servicio,
    input  logic             finalizar_pago,
    input  logic             cancelar,
    output logic             SECADO,
    output logic             LAVADO,
    output logic             LAVADO_PESADO,
    output logic             INSUFICIENTE,
    output logic             RECHAZO,
    output logic             VUELTO,
    output logic             OCUPADO,
    output logic [CNT_W-1:0] monto,
    output logic [1:0]       estado
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        PAGO       = 2'd1,
        RUN        = 2'd2,
        DEVOLUCION = 2'd3
    } estado_t;

    localparam int T_MAX = (T_PESADO > T_LAVADO) ?
                           ((T_PESADO > T_SECADO) ? T_PESADO : T_SECADO) :
                           ((T_LAVADO > T_SECADO) ? T_LAVADO : T_SECADO);
    localparam int RW = $clog2(T_MAX + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    estado_t          st, st_n;
    logic [CNT_W-1:0] monto_n, cambio, cambio_n, credito;
    logic [TW-1:0]    tcnt, tcnt_n;
    logic [RW-1:0]    rcnt, rcnt_n;
    logic [1:0]       svc, svc_n;
    logic             insuf_n, rech_n, vuelto_n, ocupado_n;
    logic             sec_n, lav_n, pes_n;
    logic             lleno, moneda_ok, valido;
    logic [CNT_W:0]   precio;
    logic [RW-1:0]    dur;

    assign estado = st;

    // Price and run length of the currently selected service; 11 is never accepted.
    always_comb begin
        valido = 1'b1;
        precio = '0;
        dur    = '0;
        case (sel_servicio)
            2'b00: begin precio = (CNT_W+1)'(PRECIO_SECADO); dur = RW'(T_SECADO - 1); end
            2'b01: begin precio = (CNT_W+1)'(PRECIO_LAVADO); dur = RW'(T_LAVADO - 1); end
            2'b10: begin precio = (CNT_W+1)'(PRECIO_PESADO); dur = RW'(T_PESADO - 1); end
            default: valido = 1'b0;
        endcase
    end

    assign lleno     = (monto == '1);
    assign moneda_ok = intro_moneda && !lleno;
    assign credito   = monto + CNT_W'(moneda_ok);

    always_comb begin
        st_n     = st;
        monto_n  = monto;
        cambio_n = cambio;
        tcnt_n   = tcnt;
        rcnt_n   = rcnt;
        svc_n    = svc;
        insuf_n  = 1'b0;
        rech_n   = 1'b0;
        vuelto_n = 1'b0;
        case (st)
            IDLE: begin
                tcnt_n = '0;
                if (intro_moneda) begin
                    st_n    = PAGO;
                    monto_n = CNT_W'(1);
                end else if (finalizar_pago) begin
                    insuf_n = 1'b1;
                end
            end
            PAGO: begin
                rech_n = intro_moneda && lleno;
                tcnt_n = intro_moneda ? '0 : tcnt + 1'b1;
                // A same-cycle coin is already folded into credito here.
                if (cancelar || (!intro_moneda && tcnt == TW'(TIMEOUT - 1))) begin
                    st_n     = DEVOLUCION;
                    cambio_n = credito;
                    monto_n  = '0;
                    tcnt_n   = '0;
                end else if (finalizar_pago) begin
                    if (valido && ({1'b0, credito} >= precio)) begin
                        st_n     = RUN;
                        svc_n    = sel_servicio;
                        rcnt_n   = dur;
                        cambio_n = credito - precio[CNT_W-1:0];
                        monto_n  = '0;
                        tcnt_n   = '0;
                    end else begin
                        insuf_n = 1'b1;
                        monto_n = credito;
                    end
                end else begin
                    monto_n = credito;
                end
            end
            RUN: begin
                rech_n = intro_moneda;
                if (rcnt == '0)
                    st_n = (cambio != '0) ? DEVOLUCION : IDLE;
                else
                    rcnt_n = rcnt - 1'b1;
            end
            DEVOLUCION: begin
                rech_n = intro_moneda;
                if (cambio != '0) begin
                    vuelto_n = 1'b1;
                    cambio_n = cambio - 1'b1;
                    if (cambio == CNT_W'(1))
                        st_n = IDLE;
                end else begin
                    st_n = IDLE;
                end
            end
            default: st_n = IDLE;
        endcase
        // Outputs are registered from the next state so they align with it.
        sec_n     = (st_n == RUN) && (svc_n == 2'b00);
        lav_n     = (st_n == RUN) && (svc_n == 2'b01);
        pes_n     = (st_n == RUN) && (svc_n == 2'b10);
        ocupado_n = (st_n == RUN) || (st_n == DEVOLUCION);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st            <= IDLE;
            monto         <= '0;
            cambio        <= '0;
            tcnt          <= '0;
            rcnt          <= '0;
            svc           <= '0;
            SECADO        <= 1'b0;
            LAVADO        <= 1'b0;
            LAVADO_PESADO <= 1'b0;
            INSUFICIENTE  <= 1'b0;
            RECHAZO       <= 1'b0;
            VUELTO        <= 1'b0;
            OCUPADO       <= 1'b0;
        end else begin
            st            <= st_n;
            monto         <= monto_n;
            cambio        <= cambio_n;
            tcnt          <= tcnt_n;
            rcnt          <= rcnt_n;
            svc           <= svc_n;
            SECADO        <= sec_n;
            LAVADO        <= lav_n;
            LAVADO_PESADO <= pes_n;
            INSUFICIENTE  <= insuf_n;
            RECHAZO       <= rech_n;
            VUELTO        <= vuelto_n;
            OCUPADO       <= ocupado_n;
        end
    end

endmodule
